// File: rtl/spi_frame_receiver.sv
// SPI mode-0 frame receiver: oversamples the host pins on CLOCK_50 and turns
// a command/address/data frame into frame-buffer write strobes.
module spi_frame_receiver #(
  parameter int         ADDR_WIDTH  = 12,
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] WRITE_CMD   = 8'hA5
) (
  input  logic                  CLOCK_50,
  input  logic                  reset_n,
  input  logic                  spi_sclk,
  input  logic                  spi_mosi,
  input  logic                  spi_cs_n,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [7:0]            wr_data,
  output logic                  frame_done,
  output logic [15:0]           byte_count,
  output logic                  cmd_err,
  input  logic                  err_clr
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ADDR_HI,
    S_ADDR_LO,
    S_DATA,
    S_DISCARD
  } state_t;

  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic                   r_sclk_d;
  logic                   r_cs_d;

  logic w_sclk_s;
  logic w_mosi_s;
  logic w_cs_s;
  logic w_sclk_rise;
  logic w_cs_fall;
  logic w_cs_rise;

  assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
  assign w_mosi_s    = r_mosi_sync[SYNC_STAGES-1];
  assign w_cs_s      = r_cs_sync[SYNC_STAGES-1];
  assign w_sclk_rise = w_sclk_s & ~r_sclk_d;
  assign w_cs_fall   = ~w_cs_s & r_cs_d;
  assign w_cs_rise   = w_cs_s & ~r_cs_d;

  // Idle levels on reset so a held-low cs_n is seen as a fresh frame start
  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      r_sclk_sync <= '0;
      r_mosi_sync <= '0;
      r_cs_sync   <= '1;
      r_sclk_d    <= 1'b0;
      r_cs_d      <= 1'b1;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], spi_sclk};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], spi_cs_n};
      r_sclk_d    <= w_sclk_s;
      r_cs_d      <= w_cs_s;
    end
  end

  logic [7:0] r_shift;
  logic [2:0] r_bit_cnt;
  logic       r_byte_ready;
  logic [7:0] r_byte;

  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      r_shift      <= '0;
      r_bit_cnt    <= '0;
      r_byte_ready <= 1'b0;
      r_byte       <= '0;
    end else begin
      r_byte_ready <= 1'b0;
      if (w_cs_fall || w_cs_rise) begin
        r_shift   <= '0;
        r_bit_cnt <= '0;
      end else if (w_sclk_rise && !w_cs_s) begin
        r_shift   <= {r_shift[6:0], w_mosi_s};
        r_bit_cnt <= r_bit_cnt + 3'd1;
        if (r_bit_cnt == 3'd7) begin
          r_byte_ready <= 1'b1;
          r_byte       <= {r_shift[6:0], w_mosi_s};
        end
      end
    end
  end

  state_t                r_state;
  logic [7:0]            r_addr_hi;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [15:0]           r_cnt;
  logic                  r_wr_en;
  logic [ADDR_WIDTH-1:0] r_wr_addr;
  logic [7:0]            r_wr_data;
  logic                  r_frame_done;
  logic [15:0]           r_byte_count;
  logic                  r_cmd_err;

  logic [15:0] w_cnt_inc;
  logic [15:0] w_cnt_close;
  logic        w_data_byte;

  assign w_cnt_inc   = (r_cnt == 16'hFFFF) ? r_cnt : r_cnt + 16'd1;
  assign w_data_byte = (r_state == S_DATA) && r_byte_ready;
  // A byte landing with the cs_n rise still counts toward the frame
  assign w_cnt_close = w_data_byte ? w_cnt_inc : r_cnt;

  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_addr_hi    <= '0;
      r_addr       <= '0;
      r_cnt        <= '0;
      r_wr_en      <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_frame_done <= 1'b0;
      r_byte_count <= '0;
      r_cmd_err    <= 1'b0;
    end else begin
      r_wr_en      <= 1'b0;
      r_frame_done <= 1'b0;
      if (err_clr)
        r_cmd_err <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_cs_fall)
            r_state <= S_CMD;
        end
        S_CMD: begin
          if (r_byte_ready) begin
            if (r_byte == WRITE_CMD) begin
              r_state <= S_ADDR_HI;
            end else begin
              r_cmd_err <= 1'b1;
              r_state   <= S_DISCARD;
            end
          end
        end
        S_ADDR_HI: begin
          if (r_byte_ready) begin
            r_addr_hi <= r_byte;
            r_state   <= S_ADDR_LO;
          end
        end
        S_ADDR_LO: begin
          if (r_byte_ready) begin
            r_addr  <= ADDR_WIDTH'({r_addr_hi, r_byte});
            r_cnt   <= '0;
            r_state <= S_DATA;
          end
        end
        S_DATA: begin
          if (r_byte_ready) begin
            r_wr_en   <= 1'b1;
            r_wr_data <= r_byte;
            r_wr_addr <= r_addr;
            r_addr    <= r_addr + ADDR_WIDTH'(1);
            r_cnt     <= w_cnt_inc;
          end
        end
        S_DISCARD: begin
        end
        default: r_state <= S_IDLE;
      endcase
      if (w_cs_rise && r_state != S_IDLE) begin
        r_state <= S_IDLE;
        if (r_state == S_DATA && w_cnt_close != 16'd0) begin
          r_byte_count <= w_cnt_close;
          r_frame_done <= 1'b1;
        end
      end
    end
  end

  assign wr_en      = r_wr_en;
  assign wr_addr    = r_wr_addr;
  assign wr_data    = r_wr_data;
  assign frame_done = r_frame_done;
  assign byte_count = r_byte_count;
  assign cmd_err    = r_cmd_err;

endmodule

// File: doc/spi_frame_receiver.md
Name: spi_frame_receiver

Overview:
- Receive side of the host-to-cube link. Deserialises an SPI mode-0 byte stream arriving on GPIO pins from the host board.
- Parses a command/address header, then emits one write strobe per data byte into the cube frame buffer, auto-incrementing the address.
- Sits between the GPIO_1 input pins and the frame-buffer write port of cube_controller.
- Runs entirely in the CLOCK_50 domain and oversamples the SPI pins.

Parameters:
- ADDR_WIDTH, 12, frame-buffer address width; the 16-bit header address is truncated to this width.
- SYNC_STAGES, 2, flip-flop stages on each of spi_sclk, spi_mosi and spi_cs_n (minimum 2).
- WRITE_CMD, 8'hA5, the only accepted command byte.

Ports:
- CLOCK_50  in  1  system clock, 50 MHz
- reset_n  in  1  synchronous active-low reset
- spi_sclk  in  1  SPI clock from host, asynchronous to CLOCK_50; frequency at most CLOCK_50/8
- spi_mosi  in  1  SPI data, MSB first, sampled on the sclk rising edge
- spi_cs_n  in  1  frame select, active low
- wr_en  out  1  one-cycle write strobe to the frame buffer
- wr_addr  out  ADDR_WIDTH  write address
- wr_data  out  8  write data
- frame_done  out  1  one-cycle pulse at the end of a valid frame
- byte_count  out  16  data bytes written in the last completed frame
- cmd_err  out  1  sticky flag: bad command byte seen
- err_clr  in  1  clears cmd_err

Behaviour:
- Reset: synchronous on the CLOCK_50 rising edge while reset_n = 0.
  - All outputs go to 0, FSM goes to IDLE, the shift register and bit counter clear, and the synchroniser flops are set to idle levels (sclk=0, cs_n=1).
  - Reset mid-frame abandons the frame: no wr_en and no frame_done are generated for it.
- Synchronisers and edge detection: each pin passes through SYNC_STAGES flops. A sclk rising edge is detected when the synchronised sclk is 1 and its previous value was 0. cs_n is handled the same way to detect falling and rising edges.
- Deserialiser:
  - On each detected sclk rising edge while synchronised cs_n = 0, shift in the synchronised mosi (MSB first) and increment the 3-bit bit counter.
  - When the counter wraps 7→0, byte_ready asserts for one cycle with the completed byte. byte_ready is registered, so it occurs in the cycle after the 8th edge is detected.
- FSM states and transitions (advance only on byte_ready):
  - IDLE → CMD on a cs_n falling edge; the bit counter clears.
  - CMD: if byte == WRITE_CMD go to ADDR_HI; otherwise set cmd_err and go to DISCARD.
  - ADDR_HI: latch the upper address byte, go to ADDR_LO.
  - ADDR_LO: form addr = {hi, lo}[ADDR_WIDTH-1:0], clear the data count, go to DATA.
  - DATA: for each byte:
    - In the cycle after byte_ready: wr_en = 1, wr_data = byte, wr_addr = current addr.
    - Then addr increments modulo 2^ADDR_WIDTH (wraps from all-ones to 0) and the count increments, saturating at 16'hFFFF.
    - Write latency is 2 CLOCK_50 cycles after detection of the 8th sclk edge.
  - DISCARD: ignore all bytes until cs_n rises.
- cs_n rising edge (from any non-IDLE state):
  - A partial byte in progress is discarded.
  - If the state is DATA with count ≥ 1: byte_count is set to the count and frame_done pulses for one cycle, in the same cycle.
  - Any other case produces no frame_done and leaves byte_count unchanged.
  - The FSM returns to IDLE.
- Same-cycle collisions:
  - If a cs_n rising edge and byte_ready fall in the same cycle, byte_ready wins first: the byte's write still issues, then the frame closes with that byte counted.
  - cmd_err: a set in the same cycle as err_clr wins, so cmd_err stays 1.
- wr_addr and wr_data hold their last values when wr_en = 0.
- Back-to-back frames are supported with no idle CLOCK_50 gap requirement beyond the SPI timing limit.

Test Plan:
- Reset during DATA: after 2 data bytes, pull reset_n low for 1 cycle → all outputs 0, no frame_done. A following clean frame works normally.
- Basic write: send A5 01 23 11 22 33, then raise cs_n → 3 wr_en pulses at addresses 0x123/0x124/0x125 with data 11/22/33; frame_done once; byte_count = 3.
- Address wrap: send A5 0F FF AA BB → writes AA@0xFFF, then BB@0x000; byte_count = 2.
- Bad command: send 5A 00 00 77 → no wr_en, no frame_done, cmd_err = 1. Pulse err_clr → cmd_err = 0. A later valid frame is unaffected.
- Abort and partial byte: send A5 00 10, then 4 bits, then raise cs_n → no wr_en and no frame_done. Send A5 00 10 with zero data bytes → no frame_done; byte_count keeps its prior value.
- Max-rate stress: sclk = CLOCK_50/8 with randomised phase, 256 random data bytes → every byte written exactly once, in order, at the correct address; byte_count = 256.
